stream_resp_cntl: RTL
=====================

Name: stream_resp_cntl

Overview:
Responder end of the PE stream-request protocol. It accepts input-activation or filter stream requests from the PE controller. For the selected channel it reads that channel's compressed entries from the on-chip buffer and streams them to the PE with valid/ready. It then pulses the matching finish strobe (input-finish or filter-finish) that the PE controller consumes.

Parameters:
DATA_W, 16, width of a compressed value
IDX_W, 8, width of the zero-run/coordinate index stored with each value
MAX_CH, 4, number of channels (matches `max_num_channel)
DEPTH, 256, buffer entries per channel per stream type
CNT_W, $clog2(DEPTH+1), width of the per-channel entry count

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
req_input_valid  in  1  request to stream input activations
req_filter_valid  in  1  request to stream filter weights
req_channel  in  $clog2(MAX_CH)  channel to stream
req_ready  out  1  high only in IDLE; a request is accepted on valid&ready
num_compressed  in  MAX_CH*CNT_W  entry count per channel, sampled at accept
valid_channel  in  MAX_CH  channel enable mask, sampled at accept
mem_rd_en  out  1  buffer read strobe
mem_rd_sel  out  1  0 = input buffer, 1 = filter buffer
mem_rd_addr  out  $clog2(MAX_CH*DEPTH)  equals channel*DEPTH + entry
mem_rd_data  in  DATA_W+IDX_W  {value, index}; valid exactly 1 cycle after mem_rd_en
strm_valid  out  1  stream beat valid
strm_data  out  DATA_W  beat value
strm_idx  out  IDX_W  beat index
strm_last  out  1  final beat of the transfer
strm_ready  in  1  PE accepts the beat
stream_input_finish  out  1  one-cycle pulse at end of an input transfer
stream_filter_finish  out  1  one-cycle pulse at end of a filter transfer

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values: all outputs are 0 except req_ready, which is 1. The FSM resets to IDLE, counters to 0 and the skid buffer to empty. Reset asserted mid-transfer aborts it: no finish pulse is issued, and any pending read data is discarded.
- FSM states and transitions:
  - IDLE: accept a request.
    - If both request valids are high, input wins; filter stays pending (its valid stays high).
    - At accept, latch the type, the channel, and cnt = num_compressed[channel].
    - If valid_channel[channel]==0 or cnt==0, go to DONE with no beats.
    - Otherwise go to READ.
  - READ: issue mem_rd_en while rd_ptr<cnt and skid occupancy + reads in flight < 2. rd_ptr increments per read. After the last read, go to DRAIN.
  - DRAIN: wait until the final beat handshakes (strm_valid & strm_ready & strm_last), then go to DONE.
  - DONE: for one cycle, pulse the finish strobe matching the latched type; then return to IDLE.
- Latency:
  - First beat: strm_valid rises 2 cycles after accept (accept, then read issue, then data captured in the skid).
  - Throughput: 1 beat/cycle with strm_ready held high.
  - Finish pulse: 1 cycle after the last handshake. Zero-length transfers pulse 1 cycle after accept.
- Handshake rules:
  - strm_data, strm_idx and strm_last are held stable while strm_valid & !strm_ready.
  - strm_valid never drops without a handshake.
  - strm_last is high only on beat cnt-1.
- Width rules:
  - Beat counter and rd_ptr are CNT_W bits; cnt==DEPTH is legal and reads entries 0..DEPTH-1.
  - Addresses never cross into the next channel.
  - Counts above DEPTH are clamped to DEPTH.

Optional Feature:
- Macro: STREAM_RESP_PERF_EN.
- When defined, adds outputs perf_beats (32-bit) and perf_stall (32-bit). Both are saturating counters.
  - perf_beats counts handshakes.
  - perf_stall counts cycles with strm_valid & !strm_ready.
  - Both clear on rst.
- When undefined, these ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Shared package (sys_defs.svh): stream-type enum (STRM_INPUT=0, STRM_FILTER=1), FSM state enum, and MAX_CH/DEPTH defaults tied to `max_num_channel and `max_size_output.
- One sub-module, stream_skid_buf: a 2-entry FIFO absorbing the 1-cycle read latency under backpressure.
  - Interface: push, push_data, pop, head, full, empty, count.

Test Plan:
- Input request, ch0, count 16, strm_ready=1 -> 16 beats at addr 0..15; strm_last on beat 16; stream_input_finish pulses once, 1 cycle after the last handshake; req_ready returns high the next cycle.
- Filter request, ch2, count 24, strm_ready toggling 1010… -> 24 beats in order, addr 2*DEPTH+0..23, data stable during stalls, no lost or duplicated beats; stream_filter_finish pulses once.
- Request for ch1 with valid_channel=3'b101 (ch1 disabled), or for any channel with count 0 -> zero beats, no mem_rd_en, finish pulse 1 cycle after accept.
- req_input_valid and req_filter_valid both high, ch0 count 4 -> input transfer first (4 beats + input finish), then filter accepted in IDLE (4 beats + filter finish).
- rst asserted after beat 5 of 16 -> next cycle all outputs at reset values, no finish pulse; a new request then completes normally.
- STREAM_RESP_PERF_EN defined, 16-beat transfer with 8 stall cycles -> perf_beats=16, perf_stall=8.

Source files
------------

// File: rtl/stream_resp_cntl_pkg.sv
// Shared types and size defaults for the stream responder (stream_resp_cntl).
// Defaults match the system max_num_channel / max_size_output settings.
package stream_resp_cntl_pkg;

    localparam int DEF_MAX_CH = 4;
    localparam int DEF_DEPTH  = 256;

    typedef enum logic {
        STRM_INPUT  = 1'b0,
        STRM_FILTER = 1'b1
    } strm_type_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_READ,
        ST_DRAIN,
        ST_DONE
    } resp_state_e;

    // Saturating increment used by the optional performance counters.
    function automatic logic [31:0] sat_inc32(input logic [31:0] v, input logic en);
        return (en && (v != 32'hFFFF_FFFF)) ? v + 32'd1 : v;
    endfunction

endpackage

// File: rtl/stream_resp_cntl_if.sv
// Beat channel between the stream responder and the PE: valid/ready with value,
// index and last marker.
interface stream_resp_cntl_if #(
    parameter int DATA_W = 16,
    parameter int IDX_W  = 8
);
    logic              valid;
    logic [DATA_W-1:0] data;
    logic [IDX_W-1:0]  idx;
    logic              last;
    logic              ready;

    modport master (output valid, data, idx, last, input ready);
    modport slave  (input valid, data, idx, last, output ready);
endinterface

// File: rtl/stream_resp_cntl_skid_buf.sv
// Two-entry FIFO that catches buffer read data one cycle after the read strobe,
// so reads can be issued ahead of PE backpressure without losing a beat.
module stream_skid_buf #(
    parameter int W = 24
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    output logic [W-1:0] head,
    output logic         full,
    output logic         empty,
    output logic [1:0]   count
);
    logic [W-1:0] slot_q [2];
    logic         wr_idx_q;
    logic         rd_idx_q;
    logic [1:0]   count_q;

    // NOTE: the slots hold payload only and validity lives in count_q, so the
    // storage is deliberately left without a reset.
    always_ff @(posedge clk) begin
        if (push) begin
            slot_q[wr_idx_q] <= push_data;
        end
    end

    // NOTE: every sequential assignment is non-blocking so all flops update
    // from the same pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_idx_q <= 1'b0;
            rd_idx_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            if (push) wr_idx_q <= ~wr_idx_q;
            if (pop)  rd_idx_q <= ~rd_idx_q;
            count_q <= count_q + 2'(push) - 2'(pop);
        end
    end

    assign head  = slot_q[rd_idx_q];
    assign full  = (count_q == 2'd2);
    assign empty = (count_q == 2'd0);
    assign count = count_q;

endmodule

// File: rtl/stream_resp_cntl.sv
// Responder end of the PE stream-request protocol: reads a channel's compressed
// entries and streams them out. Optional STREAM_RESP_PERF_EN adds perf counters.
module stream_resp_cntl
    import stream_resp_cntl_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int IDX_W  = 8,
    parameter int MAX_CH = DEF_MAX_CH,
    parameter int DEPTH  = DEF_DEPTH,
    parameter int CNT_W  = $clog2(DEPTH + 1),
    parameter int CH_W   = (MAX_CH > 1) ? $clog2(MAX_CH) : 1,
    parameter int ADDR_W = $clog2(MAX_CH * DEPTH)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    req_input_valid,
    input  logic                    req_filter_valid,
    input  logic [CH_W-1:0]         req_channel,
    output logic                    req_ready,
    input  logic [MAX_CH*CNT_W-1:0] num_compressed,
    input  logic [MAX_CH-1:0]       valid_channel,
    output logic                    mem_rd_en,
    output logic                    mem_rd_sel,
    output logic [ADDR_W-1:0]       mem_rd_addr,
    input  logic [DATA_W+IDX_W-1:0] mem_rd_data,
    stream_resp_cntl_if.master      strm,
    output logic                    stream_input_finish,
    output logic                    stream_filter_finish
`ifdef STREAM_RESP_PERF_EN
    ,
    output logic [31:0]             perf_beats,
    output logic [31:0]             perf_stall
`endif
);
    localparam int PAY_W = DATA_W + IDX_W;

    resp_state_e      state_q, state_d;
    strm_type_e       type_q;
    strm_type_e       acc_type;
    logic [CH_W-1:0]  ch_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] beat_q;
    logic             inflight_q;

    logic             accept;
    logic             pop;
    logic             rd_last;
    logic             can_issue;
    logic             sel_skip;
    logic [CNT_W-1:0] sel_raw;
    logic [CNT_W-1:0] sel_cnt;
    logic [CNT_W-1:0] rd_off;
    logic [2:0]       occ_next;

    logic [PAY_W-1:0] skid_head;
    logic             skid_full;
    logic             skid_empty;
    logic [1:0]       skid_count;

    // Request decode: input wins a tie, counts beyond one channel's storage clamp.
    assign accept   = (state_q == ST_IDLE) && (req_input_valid || req_filter_valid);
    assign acc_type = req_input_valid ? STRM_INPUT : STRM_FILTER;
    assign sel_raw  = num_compressed[int'(req_channel)*CNT_W +: CNT_W];
    assign sel_cnt  = (sel_raw > CNT_W'(DEPTH)) ? CNT_W'(DEPTH) : sel_raw;
    assign sel_skip = !valid_channel[req_channel] || (sel_cnt == '0);

    assign pop     = !skid_empty && strm.ready;
    assign rd_last = (rd_ptr_q == cnt_q - CNT_W'(1));

    // A read may issue only if its data will find a free skid slot next cycle.
    assign occ_next  = 3'(skid_count) + 3'(inflight_q) - 3'(pop);
    assign can_issue = !(skid_full && !pop) && (occ_next < 3'd2);

    // NOTE: every variable written here gets a default first, so no path
    // through the case leaves it unassigned and no latch is inferred.
    always_comb begin
        state_d   = state_q;
        mem_rd_en = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (accept) state_d = sel_skip ? ST_DONE : ST_READ;
            end
            ST_READ: begin
                if ((rd_ptr_q < cnt_q) && can_issue) begin
                    mem_rd_en = 1'b1;
                    if (rd_last) state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (pop && strm.last) state_d = ST_DONE;
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            type_q     <= STRM_INPUT;
            ch_q       <= '0;
            cnt_q      <= '0;
            rd_ptr_q   <= '0;
            beat_q     <= '0;
            inflight_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            inflight_q <= mem_rd_en;
            if (accept) begin
                type_q   <= acc_type;
                ch_q     <= req_channel;
                cnt_q    <= sel_cnt;
                rd_ptr_q <= '0;
                beat_q   <= '0;
            end else begin
                if (mem_rd_en) rd_ptr_q <= rd_ptr_q + CNT_W'(1);
                if (pop)       beat_q   <= beat_q + CNT_W'(1);
            end
        end
    end

    stream_skid_buf #(.W(PAY_W)) u_skid (
        .clk       (clk),
        .rst       (rst),
        .push      (inflight_q),
        .push_data (mem_rd_data),
        .pop       (pop),
        .head      (skid_head),
        .full      (skid_full),
        .empty     (skid_empty),
        .count     (skid_count)
    );

    // Once rd_ptr reaches a full channel the idle address stays on its last entry.
    assign rd_off      = (rd_ptr_q >= CNT_W'(DEPTH)) ? CNT_W'(DEPTH - 1) : rd_ptr_q;
    assign mem_rd_addr = ADDR_W'(ch_q) * ADDR_W'(DEPTH) + ADDR_W'(rd_off);
    assign mem_rd_sel  = (type_q == STRM_FILTER);
    assign req_ready   = (state_q == ST_IDLE);

    assign strm.valid = !skid_empty;
    assign strm.data  = skid_empty ? '0 : skid_head[PAY_W-1:IDX_W];
    assign strm.idx   = skid_empty ? '0 : skid_head[IDX_W-1:0];
    assign strm.last  = !skid_empty && (beat_q == cnt_q - CNT_W'(1));

    assign stream_input_finish  = (state_q == ST_DONE) && (type_q == STRM_INPUT);
    assign stream_filter_finish = (state_q == ST_DONE) && (type_q == STRM_FILTER);

`ifdef STREAM_RESP_PERF_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_beats <= '0;
            perf_stall <= '0;
        end else begin
            perf_beats <= sat_inc32(perf_beats, pop);
            perf_stall <= sat_inc32(perf_stall, strm.valid && !strm.ready);
        end
    end
`endif

endmodule
